// File: rtl/mac_divmod_if.sv
// Operand/result handshake bundle for the mac_divmod restoring divider.
// The master side supplies operands and consumes results; the slave side is the divider.
interface mac_divmod_if #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;
  logic                  busy;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );
endinterface

// File: rtl/mac_divmod.sv
// Sequential restoring divider: dividend = quotient*divisor + remainder, one quotient bit per clock.
// Zero divisors short-circuit to an all-ones quotient with the low dividend bits as remainder.
module mac_divmod #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  mac_divmod_if.slave    bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int         CNT_W  = $clog2(DIVIDEND_W + 1);

  logic [1:0]            state;
  logic [DIVISOR_W-1:0]  p_q;
  logic [DIVIDEND_W-1:0] shift_q;
  logic [DIVISOR_W-1:0]  div_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DIVIDEND_W-1:0] quot_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic                  dbz_q;

  logic [DIVISOR_W:0]    p_shift;
  logic [DIVISOR_W-1:0]  p_diff;
  logic [DIVISOR_W-1:0]  p_next;
  logic                  q_bit;

  // The partial remainder stays below the divisor, so after each subtract it fits in
  // DIVISOR_W bits; only the shifted value needs the extra bit for the compare.
  always_comb begin
    // NOTE: every signal assigned here gets a value on every pass, so no latch is inferred.
    p_shift = {p_q, shift_q[DIVIDEND_W-1]};
    q_bit   = (p_shift >= {1'b0, div_q});
    p_diff  = p_shift[DIVISOR_W-1:0] - div_q;
    p_next  = q_bit ? p_diff : p_shift[DIVISOR_W-1:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      p_q     <= '0;
      shift_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            div_q <= bus.divisor;
            if (bus.divisor == '0) begin
              quot_q <= '1;
              rem_q  <= bus.dividend[DIVISOR_W-1:0];
              dbz_q  <= 1'b1;
              state  <= S_DONE;
            end else begin
              dbz_q   <= 1'b0;
              p_q     <= '0;
              shift_q <= bus.dividend;
              cnt_q   <= CNT_W'(DIVIDEND_W - 1);
              state   <= S_CALC;
            end
          end
        end
        S_CALC: begin
          p_q     <= p_next;
          shift_q <= {shift_q[DIVIDEND_W-2:0], q_bit};
          cnt_q   <= cnt_q - 1'b1;
          // Last iteration: publish the freshly computed bit together with the rest.
          if (cnt_q == '0) begin
            quot_q <= {shift_q[DIVIDEND_W-2:0], q_bit};
            rem_q  <= p_next;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == S_IDLE);
  assign bus.busy        = (state == S_CALC);
  assign bus.out_valid   = (state == S_DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mac_divmod.sv
// Self-checking bench for mac_divmod: transaction-level model (/ and %) checked every cycle,
// directed MAC-inverse, boundary, backpressure and reset cases, then randomized operands.
module tb_mac_divmod;
  localparam int DW = 32;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_divmod_if #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) bus ();
  mac_divmod #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one outstanding operation, result visible 'lat' edges after accept.
  bit            op_on    = 1'b0;
  int            cyc      = 0;
  int            acc      = 0;
  int            lat      = 0;
  logic [DW-1:0] m_dd     = '0;
  logic [SW-1:0] m_dv     = '0;
  logic [DW-1:0] last_q   = '0;
  logic [SW-1:0] last_r   = '0;
  logic          last_dbz = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      op_on    = 1'b0;
      last_q   = '0;
      last_r   = '0;
      last_dbz = 1'b0;
    end else begin
      cyc++;
      if (!op_on) begin
        if (bus.in_valid) begin
          op_on = 1'b1;
          acc   = cyc;
          m_dd  = bus.dividend;
          m_dv  = bus.divisor;
          if (m_dv == 0) begin
            lat      = 0;
            last_q   = '1;
            last_r   = m_dd[SW-1:0];
            last_dbz = 1'b1;
          end else begin
            lat      = DW;
            last_dbz = 1'b0;
          end
        end
      end else if ((cyc - acc - 1) >= lat && bus.out_ready) begin
        op_on = 1'b0;
      end else if (lat != 0 && (cyc - acc) == lat) begin
        last_q = m_dd / DW'(m_dv);
        last_r = SW'(m_dd % DW'(m_dv));
      end
    end
  end

  always @(negedge clk) begin
    logic exp_v;
    exp_v = op_on && ((cyc - acc) >= lat);
    check("out_valid",   bus.out_valid,   exp_v);
    check("in_ready",    bus.in_ready,    !op_on);
    check("busy",        bus.busy,        op_on && !exp_v);
    check("quotient",    bus.quotient,    last_q);
    check("remainder",   bus.remainder,   last_r);
    check("div_by_zero", bus.div_by_zero, last_dbz);
  end

  // Drive one operation; optionally pin the result and latency to hand-computed literals.
  task automatic run_op(input logic [DW-1:0] dd, input logic [SW-1:0] dv, input int hold,
                        input bit pin, input logic [DW-1:0] pq, input logic [SW-1:0] pr,
                        input logic pz, input int plat);
    int n;
    logic [DW-1:0] q_seen;
    logic [SW-1:0] r_seen;
    n = 0;
    while (!bus.in_ready && n < 200) begin @(posedge clk); #1; n++; end
    check("in_ready_before_op", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = SW'($urandom);
    n = 0;
    while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("out_valid_timeout", bus.out_valid, 1);
    q_seen = bus.quotient;
    r_seen = bus.remainder;
    if (pin) begin
      check("lit_latency",     n,               plat);
      check("lit_quotient",    bus.quotient,    pq);
      check("lit_remainder",   bus.remainder,   pr);
      check("lit_div_by_zero", bus.div_by_zero, pz);
    end
    repeat (hold) begin
      @(posedge clk); #1;
      bus.in_valid = 1'($urandom);
      bus.dividend = $urandom;
      bus.divisor  = SW'($urandom);
      check("hold_in_ready",  bus.in_ready,  0);
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_quotient",  bus.quotient,  q_seen);
      check("hold_remainder", bus.remainder, r_seen);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("in_ready_after_pop",  bus.in_ready,  1);
    check("out_valid_after_pop", bus.out_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    logic [SW-1:0] rv;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_quotient",  bus.quotient,  0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'd699767,    16'd567,    0, 1, 32'd1234,     16'd89,     1'b0, 32);
    run_op(32'hFFFF0000,  16'hFFFF,   0, 1, 32'h00010000, 16'h0000,   1'b0, 32);
    run_op(32'hDEADBEEF,  16'd1,      0, 1, 32'hDEADBEEF, 16'h0000,   1'b0, 32);
    run_op(32'd5,         16'd9,      0, 1, 32'd0,        16'd5,      1'b0, 32);
    run_op(32'h00012345,  16'd0,      0, 1, 32'hFFFFFFFF, 16'h2345,   1'b1, 0);
    run_op(32'd1000,      16'd7,      5, 1, 32'd142,      16'd6,      1'b0, 32);
    run_op(32'd77777,     16'd100,    0, 1, 32'd777,      16'd77,     1'b0, 32);
    run_op(32'd0,         16'd13,     0, 1, 32'd0,        16'd0,      1'b0, 32);

    // Abort a division ten cycles into CALC.
    bus.in_valid = 1'b1;
    bus.dividend = 32'd100000;
    bus.divisor  = 16'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_in_ready",  bus.in_ready,  1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy",      bus.busy,      0);
    check("midrst_quotient",  bus.quotient,  0);
    check("midrst_remainder", bus.remainder, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(32'd100, 16'd7, 0, 1, 32'd14, 16'd2, 1'b0, 32);

    for (int i = 0; i < 40; i++) begin
      rd = $urandom;
      case ($urandom_range(0, 4))
        0:       rv = '0;
        1:       rv = SW'($urandom_range(1, 15));
        2:       begin rv = SW'($urandom_range(1, 65535)); rd = DW'($urandom_range(0, 32'(rv) - 1)); end
        default: rv = SW'($urandom_range(1, 65535));
      endcase
      run_op(rd, rv, $urandom_range(0, 3), 0, '0, '0, 1'b0, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mac_divmod.md
Name: mac_divmod

Overview:
- Sequential restoring divider that inverts the MAC relation R = A*B + C. Given dividend R and divisor B, it returns quotient Q and remainder Rem such that R = Q*B + Rem, with Rem < B.
- Sits downstream of the MAC datapath and is used to check, or undo, accumulated products.
- Produces one quotient bit per clock.
- Uses a valid/ready handshake on both the input side and the output side.

Parameters:
- DIVIDEND_W, 32, width of the dividend and of the quotient.
- DIVISOR_W, 16, width of the divisor and of the remainder.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  dividend/divisor presented
- in_ready  output  1  block can accept an operand pair
- dividend  input  DIVIDEND_W  unsigned dividend (R)
- divisor  input  DIVISOR_W  unsigned divisor (B)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- quotient  output  DIVIDEND_W  unsigned quotient
- remainder  output  DIVISOR_W  unsigned remainder
- div_by_zero  output  1  result came from a zero divisor
- busy  output  1  high in CALC state

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, div_by_zero=0.
  - quotient=0, remainder=0.
  - All internal registers cleared.
  - Reset mid-operation aborts the division with no output produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, the operands are captured (the "accept edge", t0).
  - If divisor==0, go to DONE:
    - quotient = all ones.
    - remainder = dividend[DIVISOR_W-1:0].
    - div_by_zero = 1.
  - Otherwise go to CALC:
    - Partial remainder P (DIVISOR_W+1 bits) = 0.
    - Shift register = dividend.
    - Bit counter = DIVIDEND_W-1.
- CALC:
  - in_ready=0, busy=1.
  - Each edge:
    - P' = {P[DIVISOR_W-1:0], shift MSB}; shift register shifts left by 1.
    - If P' >= {1'b0, divisor}: P = P' - divisor and shift in 1. Otherwise P = P' and shift in 0.
  - After DIVIDEND_W iterations (edges t0+1 .. t0+DIVIDEND_W), go to DONE:
    - quotient = shift register.
    - remainder = P[DIVISOR_W-1:0].
  - Internal compare and subtract are exactly DIVISOR_W+1 bits wide; the remainder never exceeds divisor-1.
- DONE:
  - out_valid=1; in_ready=0.
  - quotient, remainder and div_by_zero are held stable until an edge with out_ready=1. That edge returns the state to IDLE and clears out_valid.
  - quotient and remainder hold their last values in IDLE; div_by_zero is cleared at the next accept.
- Latency:
  - Normal divide: out_valid first high in the cycle after edge t0+DIVIDEND_W (32 cycles at default).
  - Divide by zero: out_valid high in the cycle after t0 (1 cycle).
- Throughput: one operation per DIVIDEND_W+2 cycles minimum, since a new accept is possible only after DONE→IDLE.
- in_valid is ignored outside IDLE. dividend and divisor may change freely after the accept edge.
- out_ready is ignored when out_valid=0.
- Boundaries:
  - dividend < divisor → quotient=0, remainder=dividend.
  - divisor=1 → quotient=dividend, remainder=0.
  - dividend=0 with non-zero divisor → quotient=0, remainder=0, full latency.
- No combinational path from any input to any output.

Test Plan:
- MAC inverse: dividend=699767 (1234*567+89), divisor=567 → quotient=1234, remainder=89, div_by_zero=0, out_valid in cycle t0+33.
- Max MAC value: dividend=32'hFFFF0000 (0xFFFF*0xFFFF+0xFFFF), divisor=16'hFFFF → quotient=32'h00010000, remainder=0.
- Edge divisors:
  - dividend=32'hDEADBEEF, divisor=1 → quotient=32'hDEADBEEF, remainder=0.
  - dividend=5, divisor=9 → quotient=0, remainder=5.
- Divide by zero: dividend=32'h00012345, divisor=0 → out_valid one cycle after accept, quotient=32'hFFFFFFFF, remainder=16'h2345, div_by_zero=1.
- Backpressure and interference: hold out_ready=0 for 5 cycles after out_valid, toggle in_valid and the operands during that time → outputs stable, in_ready=0. Then assert out_ready → in_ready=1 next cycle, and the next operation returns the correct result.
- Reset mid-operation: assert rst 10 cycles into CALC → outputs immediately zero, in_ready=1, no out_valid pulse. A fresh divide 100/7 then gives quotient=14, remainder=2.
